// File: rtl/id_pkg.sv
// Purpose: shared opcodes, lane/decoded-instruction types and the RV64 decode
//          function used by the ID dispatch front end.
// Contents: OPC_* opcode constants, lane_t, decoded_t, decode().
package id_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    LANE_INT,
    LANE_LS,
    LANE_ILL
  } lane_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic        store;
    lane_t       lane;
  } decoded_t;

  function automatic decoded_t decode(input logic [31:0] instr);
    decoded_t d;
    d.rs1    = instr[19:15];
    d.rs2    = '0;
    d.rd     = instr[11:7];
    d.opcode = instr[6:0];
    d.funct3 = instr[14:12];
    d.imm    = '0;
    d.store  = 1'b0;
    d.lane   = LANE_ILL;
    case (instr[6:0])
      OPC_OP: begin
        d.rs2  = instr[24:20];
        d.lane = LANE_INT;
      end
      OPC_OPIMM: begin
        d.imm  = instr[31:20];
        d.lane = LANE_INT;
      end
      OPC_LOAD: begin
        d.imm  = instr[31:20];
        d.lane = LANE_LS;
      end
      OPC_STORE: begin
        d.rs2   = instr[24:20];
        d.rd    = '0;
        d.imm   = {instr[31:25], instr[11:7]};
        d.store = 1'b1;
        d.lane  = LANE_LS;
      end
      default: d.lane = LANE_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_instr_fifo.sv
// Purpose: small in-order instruction queue exposing its two oldest entries.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_push, i_data      enqueue one word (caller guarantees space)
//   i_pop1, i_pop2      dequeue one / two words (mutually exclusive)
//   o_count             occupancy
//   o_head0, o_head1    oldest and second-oldest entries
module id_instr_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [31:0]   i_data,
  input  logic          i_pop1,
  input  logic          i_pop2,
  output logic [AW:0]   o_count,
  output logic [31:0]   o_head0,
  output logic [31:0]   o_head1
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_pops;
  logic [AW-1:0] w_rd_ptr1;

  assign w_pops    = i_pop2 ? (AW + 1)'(2) : (i_pop1 ? (AW + 1)'(1) : '0);
  assign w_rd_ptr1 = r_rd_ptr + AW'(1);

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= r_rd_ptr + w_pops[AW-1:0];
      r_count  <= r_count + {{AW{1'b0}}, i_push} - w_pops;
    end
  end

  assign o_count = r_count;
  assign o_head0 = r_mem[r_rd_ptr];
  assign o_head1 = r_mem[w_rd_ptr1];

endmodule

// File: rtl/id_dual_dispatch.sv
// Purpose: in-order decode/dispatch front end; queues fetched instructions and
//          each cycle sends up to one to the INT lane and one to the LS lane.
// Ports:
//   clk, res                 clock, async active-high reset
//   instr_in/valid_in/ready_out  fetch handshake
//   full_rob2ii/full_rsint2id/full_rsls2id  backpressure (any one stalls)
//   valid_int + INT fields   registered INT-lane slot
//   valid_ls + LS fields     registered LS-lane slot, store flags a store
//   illegal_err              sticky: an unsupported opcode was dropped
module id_dual_dispatch
  import id_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] instr_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        full_rob2ii,
  input  logic        full_rsint2id,
  input  logic        full_rsls2id,
  output logic        valid_int,
  output logic [4:0]  rs1_int,
  output logic [4:0]  rs2_int,
  output logic [4:0]  rd_int,
  output logic [6:0]  opcode_int,
  output logic [2:0]  funct3_int,
  output logic [11:0] imm_int,
  output logic        valid_ls,
  output logic [4:0]  rs1_ls,
  output logic [4:0]  rs2_ls,
  output logic [4:0]  rd_ls,
  output logic [6:0]  opcode_ls,
  output logic [2:0]  funct3_ls,
  output logic [11:0] imm_ls,
  output logic        store,
  output logic        illegal_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW:0] w_count;
  logic [31:0] w_head0, w_head1;
  decoded_t    w_d0, w_d1, w_int_src, w_ls_src;
  logic        w_push, w_stall, w_go, w_pair, w_pop1, w_pop2;
  logic        w_int_fire, w_ls_fire;

  logic        r_valid_int, r_valid_ls, r_illegal;
  decoded_t    r_int, r_ls;

  id_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst   (res),
    .i_push  (w_push),
    .i_data  (instr_in),
    .i_pop1  (w_pop1),
    .i_pop2  (w_pop2),
    .o_count (w_count),
    .o_head0 (w_head0),
    .o_head1 (w_head1)
  );

  assign ready_out = ~res & (w_count < CW'(DEPTH));
  assign w_push    = valid_in & ready_out;

  assign w_d0 = decode(w_head0);
  assign w_d1 = decode(w_head1);

  assign w_stall = full_rob2ii | full_rsint2id | full_rsls2id;
  assign w_go    = ~w_stall & (w_count != '0);

  // H1 only rides along with a legal H0 on the other lane, keeping order.
  assign w_pair = w_go && (w_count >= CW'(2)) && (w_d0.lane != LANE_ILL) &&
                  (w_d1.lane != LANE_ILL) && (w_d1.lane != w_d0.lane);
  assign w_pop1 = w_go & ~w_pair;
  assign w_pop2 = w_pair;

  assign w_int_fire = w_go && ((w_d0.lane == LANE_INT) || (w_pair && w_d1.lane == LANE_INT));
  assign w_ls_fire  = w_go && ((w_d0.lane == LANE_LS) || (w_pair && w_d1.lane == LANE_LS));
  assign w_int_src  = (w_d0.lane == LANE_INT) ? w_d0 : w_d1;
  assign w_ls_src   = (w_d0.lane == LANE_LS) ? w_d0 : w_d1;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_valid_int <= 1'b0;
      r_valid_ls  <= 1'b0;
      r_illegal   <= 1'b0;
      r_int       <= '0;
      r_ls        <= '0;
    end else begin
      r_valid_int <= w_int_fire;
      r_valid_ls  <= w_ls_fire;
      if (w_int_fire) r_int <= w_int_src;
      if (w_ls_fire) r_ls <= w_ls_src;
      if (w_go && w_d0.lane == LANE_ILL) r_illegal <= 1'b1;
    end
  end

  assign valid_int   = r_valid_int;
  assign rs1_int     = r_int.rs1;
  assign rs2_int     = r_int.rs2;
  assign rd_int      = r_int.rd;
  assign opcode_int  = r_int.opcode;
  assign funct3_int  = r_int.funct3;
  assign imm_int     = r_int.imm;
  assign valid_ls    = r_valid_ls;
  assign rs1_ls      = r_ls.rs1;
  assign rs2_ls      = r_ls.rs2;
  assign rd_ls       = r_ls.rd;
  assign opcode_ls   = r_ls.opcode;
  assign funct3_ls   = r_ls.funct3;
  assign imm_ls      = r_ls.imm;
  assign store       = r_ls.store;
  assign illegal_err = r_illegal;

endmodule

// File: tb/tb_id_dual_dispatch.sv
module tb_id_dual_dispatch;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic        st;
  } exp_t;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [31:0] instr_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        full_rob2ii = 1'b0, full_rsint2id = 1'b0, full_rsls2id = 1'b0;
  logic        valid_int, valid_ls, store, illegal_err;
  logic [4:0]  rs1_int, rs2_int, rd_int, rs1_ls, rs2_ls, rd_ls;
  logic [6:0]  opcode_int, opcode_ls;
  logic [2:0]  funct3_int, funct3_ls;
  logic [11:0] imm_int, imm_ls;

  int checks = 0;
  int errors = 0;
  exp_t q_int[$];
  exp_t q_ls[$];

  id_dual_dispatch #(.DEPTH(4)) dut (
    .clk           (clk),
    .res           (res),
    .instr_in      (instr_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .full_rob2ii   (full_rob2ii),
    .full_rsint2id (full_rsint2id),
    .full_rsls2id  (full_rsls2id),
    .valid_int     (valid_int),
    .rs1_int       (rs1_int),
    .rs2_int       (rs2_int),
    .rd_int        (rd_int),
    .opcode_int    (opcode_int),
    .funct3_int    (funct3_int),
    .imm_int       (imm_int),
    .valid_ls      (valid_ls),
    .rs1_ls        (rs1_ls),
    .rs2_ls        (rs2_ls),
    .rd_ls         (rd_ls),
    .opcode_ls     (opcode_ls),
    .funct3_ls     (funct3_ls),
    .imm_ls        (imm_ls),
    .store         (store),
    .illegal_err   (illegal_err)
  );

  always #5 clk = ~clk;

  // Reference field extraction straight from the RV instruction formats.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    e.rs1 = w[19:15];
    e.rd  = w[11:7];
    e.op  = w[6:0];
    e.f3  = w[14:12];
    e.rs2 = 5'd0;
    e.imm = 12'd0;
    e.st  = 1'b0;
    if (w[6:0] == 7'h33) e.rs2 = w[24:20];
    if (w[6:0] == 7'h13 || w[6:0] == 7'h03) e.imm = w[31:20];
    if (w[6:0] == 7'h23) begin
      e.rs2 = w[24:20];
      e.rd  = 5'd0;
      e.imm = {w[31:25], w[11:7]};
      e.st  = 1'b1;
    end
    return e;
  endfunction

  task automatic sb_push(input logic [31:0] w);
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) q_int.push_back(model(w));
    else if (w[6:0] == 7'h03 || w[6:0] == 7'h23) q_ls.push_back(model(w));
  endtask

  // Called just after a negedge; returns at the negedge following the transfer edge.
  task automatic push(input logic [31:0] w);
    int guard = 0;
    instr_in = w;
    valid_in = 1'b1;
    while (!ready_out && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!ready_out) begin
      errors++;
      $display("FAIL push_timeout ready_out=%0b required 1", ready_out);
    end
    sb_push(w);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Scoreboard: every dispatched slot must match the next expected entry of its lane.
  always @(negedge clk) begin
    if (!res) begin
      if (valid_int) begin
        checks++;
        if (q_int.size() == 0) begin
          errors++;
          $display("FAIL sb_int_unexpected rd=%0d required no dispatch", rd_int);
        end else begin
          exp_t e = q_int.pop_front();
          exp_t a = '{rs1_int, rs2_int, rd_int, opcode_int, funct3_int, imm_int, 1'b0};
          if (a !== e) begin
            errors++;
            $display("FAIL sb_int got %h required %h", a, e);
          end
        end
      end
      if (valid_ls) begin
        checks++;
        if (q_ls.size() == 0) begin
          errors++;
          $display("FAIL sb_ls_unexpected rd=%0d required no dispatch", rd_ls);
        end else begin
          exp_t e = q_ls.pop_front();
          exp_t a = '{rs1_ls, rs2_ls, rd_ls, opcode_ls, funct3_ls, imm_ls, store};
          if (a !== e) begin
            errors++;
            $display("FAIL sb_ls got %h required %h", a, e);
          end
        end
      end
    end
  end

  task automatic test_reset();
    #1;
    checks++;
    if ({valid_int, valid_ls, illegal_err, ready_out, rd_int, rd_ls} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0",
               {valid_int, valid_ls, illegal_err, ready_out, rd_int, rd_ls});
    end
    @(negedge clk);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b1 || illegal_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ready=%0b err=%0b required 1 0", ready_out, illegal_err);
    end
  endtask

  task automatic test_single_load();
    push(32'h0000_3083);  // ld x1,0(x0)
    checks++;
    if (valid_ls !== 1'b0) begin
      errors++;
      $display("FAIL load_latency valid_ls=%0b required 0", valid_ls);
    end
    @(negedge clk);
    checks++;
    if (valid_ls !== 1'b1 || rd_ls !== 5'd1 || store !== 1'b0 || valid_int !== 1'b0) begin
      errors++;
      $display("FAIL load_dispatch vls=%0b rd=%0d st=%0b vint=%0b required 1 1 0 0",
               valid_ls, rd_ls, store, valid_int);
    end
  endtask

  task automatic test_pair();
    full_rsls2id = 1'b1;
    push(32'h0020_81B3);  // add x3,x1,x2
    push(32'h0000_3103);  // ld x2,0(x0)
    full_rsls2id = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_int !== 1'b1 || valid_ls !== 1'b1 || rd_int !== 5'd3 || rs1_int !== 5'd1 ||
        rs2_int !== 5'd2 || rd_ls !== 5'd2) begin
      errors++;
      $display("FAIL pair vint=%0b vls=%0b rd=%0d rs1=%0d rs2=%0d rdls=%0d required 1 1 3 1 2 2",
               valid_int, valid_ls, rd_int, rs1_int, rs2_int, rd_ls);
    end
    @(negedge clk);
    checks++;
    if (valid_int !== 1'b0 || valid_ls !== 1'b0) begin
      errors++;
      $display("FAIL pair_after vint=%0b vls=%0b required 0 0", valid_int, valid_ls);
    end
  endtask

  task automatic test_same_lane();
    full_rob2ii = 1'b1;
    push(32'h0000_00B3);  // add x1,x0,x0
    push(32'h0000_0133);  // add x2,x0,x0
    full_rob2ii = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++;
      if (valid_int !== 1'b1 || rd_int !== 5'(i) || valid_ls !== 1'b0) begin
        errors++;
        $display("FAIL same_lane%0d vint=%0b rd=%0d vls=%0b required 1 %0d 0",
                 i, valid_int, rd_int, valid_ls, i);
      end
    end
    @(negedge clk);
    checks++;
    if (valid_int !== 1'b0) begin
      errors++;
      $display("FAIL same_lane_end vint=%0b required 0", valid_int);
    end
  endtask

  task automatic test_full_drain();
    full_rob2ii = 1'b1;
    for (int i = 4; i <= 7; i++) push({20'd0, 5'(i), 7'h33});  // add xi,x0,x0
    checks++;
    if (ready_out !== 1'b0 || valid_int !== 1'b0 || valid_ls !== 1'b0) begin
      errors++;
      $display("FAIL full_stall ready=%0b vint=%0b vls=%0b required 0 0 0",
               ready_out, valid_int, valid_ls);
    end
    full_rob2ii = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b1 || valid_int !== 1'b1 || rd_int !== 5'd4) begin
      errors++;
      $display("FAIL drain_first ready=%0b vint=%0b rd=%0d required 1 1 4",
               ready_out, valid_int, rd_int);
    end
    for (int i = 5; i <= 7; i++) begin
      @(negedge clk);
      checks++;
      if (valid_int !== 1'b1 || rd_int !== 5'(i)) begin
        errors++;
        $display("FAIL drain_order vint=%0b rd=%0d required 1 %0d", valid_int, rd_int, i);
      end
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    push(32'h0000_007F);
    push(32'h0000_0433);  // add x8,x0,x0
    checks++;
    if (illegal_err !== 1'b1 || valid_int !== 1'b0 || valid_ls !== 1'b0) begin
      errors++;
      $display("FAIL illegal_drop err=%0b vint=%0b vls=%0b required 1 0 0",
               illegal_err, valid_int, valid_ls);
    end
    @(negedge clk);
    checks++;
    if (valid_int !== 1'b1 || rd_int !== 5'd8 || illegal_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_next vint=%0b rd=%0d err=%0b required 1 8 1",
               valid_int, rd_int, illegal_err);
    end
  endtask

  task automatic test_reset_mid_drain();
    full_rsint2id = 1'b1;
    push(32'h0000_04B3);  // add x9
    push(32'h0000_0533);  // add x10
    push(32'h0000_05B3);  // add x11
    full_rsint2id = 1'b0;
    @(negedge clk);
    #2 res = 1'b1;
    #1;
    checks++;
    if (valid_int !== 1'b0 || rd_int !== 5'd0 || illegal_err !== 1'b0 || ready_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset vint=%0b rd=%0d err=%0b ready=%0b required 0 0 0 0",
               valid_int, rd_int, illegal_err, ready_out);
    end
    q_int.delete();
    q_ls.delete();
    @(negedge clk);
    res = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ready_out !== 1'b1 || valid_int !== 1'b0 || valid_ls !== 1'b0) begin
        errors++;
        $display("FAIL post_reset ready=%0b vint=%0b vls=%0b required 1 0 0",
                 ready_out, valid_int, valid_ls);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_pair();
    test_same_lane();
    test_full_drain();
    test_illegal();
    test_reset_mid_drain();
    @(negedge clk);
    checks++;
    if (q_int.size() != 0 || q_ls.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover int=%0d ls=%0d required 0 0", q_int.size(), q_ls.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
